// File: rtl/cargador_programa.sv
// cargador_programa: loads the instruction memory from a byte stream while holding the core in reset.
//   clk_i, rst_n_i          clock and asynchronous active-low reset
//   start_i                 pulse that begins a load (honoured in IDLE, DONE, ERROR)
//   byte_valid_i/byte_data_i received byte strobe and data
//   imem_we_o/addr/wdata    one-cycle write per assembled 32-bit little-endian word
//   cpu_rst_o               core reset, high while loading or after an aborted load
//   busy_o, done_o, error_o load in progress, last load completed, last load aborted
module cargador_programa #(
   parameter int ADDR_WIDTH     = 10,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_data_i,
   output logic                  imem_we_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [31:0]           imem_wdata_o,
   output logic                  cpu_rst_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o
);
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, WORD, FLUSH, DONE, ERROR} state_t;
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   // 17 bits so that a full 2**16-word memory is still representable
   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;
   state_t                state_q, state_d;
   logic [15:0]           count_q, count_d;
   logic [15:0]           widx_q, widx_d;
   logic [1:0]            bidx_q, bidx_d;
   logic [23:0]           word_q, word_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  busy_q, busy_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  loading;
   logic [15:0]           len_full;
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      widx_d    = widx_q;
      bidx_d    = bidx_q;
      word_d    = word_q;
      tmo_d     = tmo_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      loading   = state_q inside {LEN_LO, LEN_HI, WORD};
      len_full  = {byte_data_i, count_q[7:0]};
      if (start_i && state_q inside {IDLE, DONE, ERROR}) begin
         state_d = LEN_LO;
         widx_d  = '0;
         bidx_d  = '0;
         tmo_d   = '0;
      end else if (loading && byte_valid_i) begin
         tmo_d = '0;
         case (state_q)
            LEN_LO: begin
               count_d[7:0] = byte_data_i;
               state_d      = LEN_HI;
            end
            LEN_HI: begin
               count_d = len_full;
               widx_d  = '0;
               bidx_d  = '0;
               state_d = len_full == 16'd0 ? FLUSH :
                         {1'b0, len_full} > MAX_WORDS ? ERROR : WORD;
            end
            default: begin
               // bytes 0..2 shift in from the top so byte 0 ends in the low lane
               word_d = {byte_data_i, word_q[23:8]};
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = widx_q[ADDR_WIDTH-1:0];
                  wdata_d = {byte_data_i, word_q};
                  widx_d  = widx_q + 16'd1;
                  state_d = widx_q == count_q - 16'd1 ? FLUSH : WORD;
               end
            end
         endcase
      end else if (loading) begin
         if (tmo_q == TW'(TIMEOUT_CYCLES - 1))
            state_d = ERROR;
         else
            tmo_d = tmo_q + TW'(1);
      end else if (state_q == FLUSH) begin
         state_d = DONE;
      end
      // status outputs are registered from the next state
      busy_d    = state_d inside {LEN_LO, LEN_HI, WORD, FLUSH};
      cpu_rst_d = state_d inside {LEN_LO, LEN_HI, WORD, FLUSH, ERROR};
      done_d    = state_d == DONE;
      error_d   = state_d == ERROR;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         count_q   <= '0;
         widx_q    <= '0;
         bidx_q    <= '0;
         word_q    <= '0;
         tmo_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         cpu_rst_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         widx_q    <= widx_d;
         bidx_q    <= bidx_d;
         word_q    <= word_d;
         tmo_q     <= tmo_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         cpu_rst_q <= cpu_rst_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end
   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign cpu_rst_o    = cpu_rst_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;
endmodule

// File: tb/tb_cargador_programa.sv
// tb_cargador_programa: randomized scoreboard bench for the program loader.
module tb_cargador_programa;
   localparam int AW = 4;
   localparam int TMO = 100;
   logic          clk = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          start_i = 1'b0;
   logic          byte_valid_i = 1'b0;
   logic [7:0]    byte_data_i = '0;
   logic          imem_we_o;
   logic [AW-1:0] imem_addr_o;
   logic [31:0]   imem_wdata_o;
   logic          cpu_rst_o, busy_o, done_o, error_o;
   int            vectors = 0;
   int            miscompares = 0;
   int            exp_addr[$];
   logic [31:0]   exp_data[$];
   logic [7:0]    stim[$];
   logic          prev_we = 1'b0;
   cargador_programa #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i),
      .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
      .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
      .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask
   // monitor: every write must match the oldest expected write
   always @(negedge clk) begin
      if (imem_we_o) begin
         chk("we_spacing", 32'(prev_we), 32'd0);
         if (exp_addr.size() == 0)
            chk("write_expected", 32'(exp_addr.size()), 32'd1);
         else begin
            chk("waddr", 32'(imem_addr_o), 32'(exp_addr.pop_front()));
            chk("wdata", imem_wdata_o, exp_data.pop_front());
         end
      end
      prev_we = imem_we_o;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   // all tasks start and end 1 time unit after a rising edge
   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask
   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin @(posedge clk); #1; end
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      @(posedge clk); #1;
      byte_valid_i = 1'b0;
   endtask
   task automatic chk_status(input string tag, input logic b, input logic c, input logic d, input logic e);
      chk({tag, "_busy"}, 32'(busy_o), 32'(b));
      chk({tag, "_cpu_rst"}, 32'(cpu_rst_o), 32'(c));
      chk({tag, "_done"}, 32'(done_o), 32'(d));
      chk({tag, "_error"}, 32'(error_o), 32'(e));
   endtask
   // model: words are 4-byte little-endian groups after a 16-bit LE count
   task automatic run_stim(input int bust_at);
      int  n;
      bit  over;
      n    = {stim[1], stim[0]};
      over = n > (1 << AW);
      if (!over)
         for (int i = 0; i < n; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back({stim[4*i+5], stim[4*i+4], stim[4*i+3], stim[4*i+2]});
         end
      pulse_start();
      chk_status("start", 1, 1, 0, 0);
      for (int i = 0; i < stim.size(); i++) begin
         if (i == bust_at) pulse_start();
         send_byte(stim[i], $urandom_range(0, 3));
      end
      if (over)
         chk_status("oversize", 0, 1, 0, 1);
      else begin
         chk_status("flush", 1, 1, 0, 0);
         @(posedge clk); #1;
         chk_status("done", 0, 0, 1, 0);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("writes_left", 32'(exp_addr.size()), 32'd0);
   endtask
   task automatic rand_stim(input int n);
      stim = {};
      stim.push_back(n[7:0]);
      stim.push_back(n[15:8]);
      if (n <= (1 << AW))
         for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom_range(0, 255)));
   endtask
   initial begin
      int k;
      #1;
      chk("rst_we", 32'(imem_we_o), 0);
      chk_status("rst", 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 rst_n_i = 1'b1;
      @(posedge clk); #1;
      chk_status("idle", 0, 0, 0, 0);
      // two-word load
      stim = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
      run_stim(-1);
      // zero length
      stim = {8'h00, 8'h00};
      run_stim(-1);
      // oversize by one word, then a new start clears the error
      stim = {8'h11, 8'h00};
      run_stim(-1);
      // exact-capacity load with a start pulse in the middle of WORD
      rand_stim(1 << AW);
      run_stim(9);
      // timeout: count of one, two data bytes, then silence
      pulse_start();
      send_byte(8'h01, 1); send_byte(8'h00, 2); send_byte(8'h13, 0); send_byte(8'h05, 1);
      k = 0;
      while (!error_o && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      chk("timeout_cycles", 32'(k), TMO);
      chk_status("timeout", 0, 1, 0, 1);
      // random loads including large oversize counts
      for (int t = 0; t < 8; t++) begin
         rand_stim(t == 3 ? $urandom_range(17, 65535) : $urandom_range(0, 1 << AW));
         run_stim(t == 5 ? 6 : -1);
      end
      // asynchronous reset in the middle of the second word
      pulse_start();
      stim = {8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      exp_addr.push_back(0);
      exp_data.push_back(32'h44332211);
      foreach (stim[i]) send_byte(stim[i], 1);
      #2 rst_n_i = 1'b0;
      #1;
      chk("midrst_we", 32'(imem_we_o), 0);
      chk("midrst_addr", 32'(imem_addr_o), 0);
      chk("midrst_wdata", imem_wdata_o, 0);
      chk_status("midrst", 0, 0, 0, 0);
      chk("midrst_writes", 32'(exp_addr.size()), 0);
      repeat (2) @(posedge clk);
      #1 rst_n_i = 1'b1;
      @(posedge clk); #1;
      chk_status("postrst", 0, 0, 0, 0);
      // a full load after reset
      rand_stim(3);
      run_stim(-1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
